// File: rtl/text_lcd_responder.sv
// HD44780-style 2x16 character LCD model driven from the textlcd bus.
// Ports: clk_i/rst_ni (async active-low); lcd_*_i bus inputs; rd_index_i/rd_char_o
//   registered cell read; wr_*_o per-write strobe; cursor/display/line state; sticky errors.
module text_lcd_responder #(
  parameter int unsigned MIN_E_HIGH = 2,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       lcd_e_i,
  input  logic       lcd_rs_i,
  input  logic       lcd_rw_i,
  input  logic [7:0] lcd_data_i,
  input  logic [4:0] rd_index_i,
  output logic [7:0] rd_char_o,
  output logic       wr_strobe_o,
  output logic [4:0] wr_index_o,
  output logic [7:0] wr_char_o,
  output logic [6:0] cursor_addr_o,
  output logic       display_on_o,
  output logic       two_line_o,
  output logic       err_short_o,
  output logic       err_read_o
);

  localparam int unsigned CW = (MIN_E_HIGH < 1) ? 1 : $clog2(MIN_E_HIGH + 1);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_E_HIGH);

  // Bus sample layout: {e, rs, rw, data[7:0]}
  logic [10:0] s1_q, s2_q, s3_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [6:0] addr_q, addr_d;
  logic       id_q, id_d;
  logic       don_q, don_d;
  logic       twol_q, twol_d;
  logic       es_q, es_d;
  logic       er_q, er_d;
  logic       stb_q, stb_d;
  logic [4:0] widx_q, widx_d;
  logic [7:0] wchar_q, wchar_d;
  logic [7:0] rd_q;
  logic [7:0] ram_q [32];

  logic       ram_we, ram_clr;
  logic [4:0] ram_idx;

  logic       fall;
  logic       c_rs, c_rw;
  logic [7:0] c_dat;

  // Stage 3 still holds the last high-E sample when the fall is seen in stage 2,
  // so its rs/rw/data are the values the LCD would latch.
  assign fall  = s3_q[10] & ~s2_q[10];
  assign c_rs  = s3_q[9];
  assign c_rw  = s3_q[8];
  assign c_dat = s3_q[7:0];

  // DDRAM counter stepping: the two 40-byte line windows are chained into a ring.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (fall)
      cnt_d = '0;
    else if (s2_q[10] && (cnt_q < MIN_C))
      cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    addr_d  = addr_q;
    id_d    = id_q;
    don_d   = don_q;
    twol_d  = twol_q;
    es_d    = es_q;
    er_d    = er_q;
    stb_d   = 1'b0;
    widx_d  = widx_q;
    wchar_d = wchar_q;
    ram_we  = 1'b0;
    ram_clr = 1'b0;
    ram_idx = {addr_q[6], addr_q[3:0]};
    if (fall) begin
      if (cnt_q < MIN_C) begin
        es_d = 1'b1;
      end else if (c_rw) begin
        er_d = 1'b1;
      end else if (!c_rs) begin
        casez (c_dat)
          8'b1???????: addr_d = c_dat[6:0];
          8'b01??????: ;                      // CGRAM address: no CGRAM modelled
          8'b001?????: twol_d = c_dat[3];
          8'b0001????: ;                      // cursor/display shift: not modelled
          8'b00001???: don_d  = c_dat[2];
          8'b000001??: id_d   = c_dat[1];
          8'b0000001?: addr_d = 7'h00;
          8'b00000001: begin
            ram_clr = 1'b1;
            addr_d  = 7'h00;
            id_d    = 1'b1;
          end
          default: ;
        endcase
      end else begin
        // Only 0x00-0x0F and 0x40-0x4F map onto the 16-wide visible window.
        if (addr_q[5:4] == 2'b00) begin
          ram_we  = 1'b1;
          stb_d   = 1'b1;
          widx_d  = ram_idx;
          wchar_d = c_dat;
        end
        addr_d = step_addr(addr_q, id_q);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= 7'h00;
      id_q    <= 1'b1;
      don_q   <= 1'b0;
      twol_q  <= 1'b0;
      es_q    <= 1'b0;
      er_q    <= 1'b0;
      stb_q   <= 1'b0;
      widx_q  <= 5'd0;
      wchar_q <= 8'h00;
    end else begin
      s1_q    <= {lcd_e_i, lcd_rs_i, lcd_rw_i, lcd_data_i};
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      don_q   <= don_d;
      twol_q  <= twol_d;
      es_q    <= es_d;
      er_q    <= er_d;
      stb_q   <= stb_d;
      widx_q  <= widx_d;
      wchar_q <= wchar_d;
    end
  end

  // Read uses the pre-edge array contents, so a same-cycle write returns the old value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q <= BLANK_CHAR;
      for (int i = 0; i < 32; i++) ram_q[i] <= BLANK_CHAR;
    end else begin
      rd_q <= ram_q[rd_index_i];
      if (ram_clr) begin
        for (int i = 0; i < 32; i++) ram_q[i] <= BLANK_CHAR;
      end else if (ram_we) begin
        ram_q[ram_idx] <= c_dat;
      end
    end
  end

  assign rd_char_o     = rd_q;
  assign wr_strobe_o   = stb_q;
  assign wr_index_o    = widx_q;
  assign wr_char_o     = wchar_q;
  assign cursor_addr_o = addr_q;
  assign display_on_o  = don_q;
  assign two_line_o    = twol_q;
  assign err_short_o   = es_q;
  assign err_read_o    = er_q;

endmodule

// File: tb/tb_text_lcd_responder.sv
// Testbench for text_lcd_responder: directed bus cycles followed by random ones,
// compared against a cell-array model of the LCD.
module tb_text_lcd_responder;

  localparam int MIN = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;
  logic [4:0] rd_index;
  logic [7:0] rd_char;
  logic       wr_strobe;
  logic [4:0] wr_index;
  logic [7:0] wr_char;
  logic [6:0] cursor_addr;
  logic       display_on, two_line, err_short, err_read;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [7:0] m_ram [32];
  int         m_addr;
  bit         m_id, m_don, m_twol, m_es, m_er;

  always #5 clk = ~clk;

  text_lcd_responder #(.MIN_E_HIGH(MIN), .BLANK_CHAR(8'h20)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lcd_e_i(lcd_e), .lcd_rs_i(lcd_rs), .lcd_rw_i(lcd_rw), .lcd_data_i(lcd_data),
    .rd_index_i(rd_index), .rd_char_o(rd_char),
    .wr_strobe_o(wr_strobe), .wr_index_o(wr_index), .wr_char_o(wr_char),
    .cursor_addr_o(cursor_addr), .display_on_o(display_on), .two_line_o(two_line),
    .err_short_o(err_short), .err_read_o(err_read)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cell_of(input int a);
    if (a < 16) return a;
    if (a >= 64 && a < 80) return a - 48;
    return -1;
  endfunction

  function automatic int next_addr(input int a, input bit inc);
    if (inc) begin
      if (a == 39)  return 64;
      if (a == 103) return 0;
      return (a + 1) % 128;
    end
    if (a == 0)  return 103;
    if (a == 64) return 39;
    return (a + 127) % 128;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
    m_addr = 0; m_id = 1'b1;
    m_don = 1'b0; m_twol = 1'b0; m_es = 1'b0; m_er = 1'b0;
  endtask

  task automatic chk_state();
    chk("cursor_addr", 32'(cursor_addr), 32'(m_addr));
    chk("display_on",  32'(display_on),  32'(m_don));
    chk("two_line",    32'(two_line),    32'(m_twol));
    chk("err_short",   32'(err_short),   32'(m_es));
    chk("err_read",    32'(err_read),    32'(m_er));
  endtask

  task automatic check_ram();
    for (int i = 0; i < 32; i++) begin
      rd_index = 5'(i);
      @(negedge clk);
      chk($sformatf("rd_char[%0d]", i), 32'(rd_char), 32'(m_ram[i]));
    end
  endtask

  // One full bus cycle with E high for 'hi' clocks, then model update and checks.
  task automatic bus(input bit trs, input bit trw, input logic [7:0] d, input int hi);
    int  dv, c, exp_idx;
    bit  exp_stb;
    lcd_rs = trs; lcd_rw = trw; lcd_data = d;
    @(negedge clk);
    lcd_e = 1'b1;
    repeat (hi) @(negedge clk);
    lcd_e = 1'b0;
    exp_stb = 1'b0; exp_idx = 0; dv = int'(d);
    if (hi < MIN) m_es = 1'b1;
    else if (trw) m_er = 1'b1;
    else if (!trs) begin
      if (dv >= 128)     m_addr = dv - 128;
      else if (dv >= 64) ;
      else if (dv >= 32) m_twol = ((dv >> 3) & 1) != 0;
      else if (dv >= 16) ;
      else if (dv >= 8)  m_don = ((dv >> 2) & 1) != 0;
      else if (dv >= 4)  m_id = ((dv >> 1) & 1) != 0;
      else if (dv >= 2)  m_addr = 0;
      else if (dv == 1) begin
        for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
        m_addr = 0; m_id = 1'b1;
      end
    end else begin
      c = cell_of(m_addr);
      if (c >= 0) begin
        m_ram[c] = d; exp_stb = 1'b1; exp_idx = c;
      end
      m_addr = next_addr(m_addr, m_id);
    end
    @(negedge clk);
    @(negedge clk);
    chk("strobe_early", 32'(wr_strobe), 32'd0);
    @(negedge clk);
    chk("wr_strobe", 32'(wr_strobe), 32'(exp_stb));
    if (exp_stb) begin
      chk("wr_index", 32'(wr_index), 32'(exp_idx));
      chk("wr_char",  32'(wr_char),  32'(d));
    end
    chk_state();
    @(negedge clk);
    chk("strobe_off", 32'(wr_strobe), 32'd0);
  endtask

  initial begin
    int r, hi, sel;
    logic [7:0] d;
    rst_n = 1'b0; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
    lcd_data = 8'h00; rd_index = 5'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_strobe", 32'(wr_strobe), 32'd0);
    chk("rst_rd_char", 32'(rd_char), 32'h20);
    rst_n = 1'b1;
    @(negedge clk);
    chk_state();
    check_ram();

    // Initialisation sequence
    bus(0, 0, 8'h38, 2);
    bus(0, 0, 8'h0C, 2);
    bus(0, 0, 8'h06, 2);
    bus(0, 0, 8'h01, 3);
    check_ram();

    // "1+1="
    bus(1, 0, 8'h31, 2);
    bus(1, 0, 8'h2B, 2);
    bus(1, 0, 8'h31, 3);
    bus(1, 0, 8'h3D, 2);
    check_ram();

    // Last visible cell of line 2, then off-screen write
    bus(0, 0, 8'hCF, 2);
    bus(1, 0, 8'h41, 2);
    bus(1, 0, 8'h42, 2);

    // Decrement mode wrap at 0x00 and below 0x28
    bus(0, 0, 8'h04, 2);
    bus(0, 0, 8'h80, 2);
    bus(1, 0, 8'h39, 2);
    bus(0, 0, 8'hA7, 2);
    bus(1, 0, 8'h30, 2);
    check_ram();

    // Rejected short pulse and read cycle
    bus(1, 0, 8'h77, 1);
    bus(0, 1, 8'h00, 2);
    check_ram();

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      r  = int'($urandom_range(0, 9));
      hi = ($urandom_range(0, 7) == 0) ? 1 : int'($urandom_range(2, 4));
      d  = 8'($urandom_range(0, 255));
      case (r)
        0, 1, 2, 3, 4: bus(1, 0, d, hi);
        5: begin
          sel = int'($urandom_range(0, 3));
          case (sel)
            0: d = 8'h80 | 8'($urandom_range(0, 15));
            1: d = 8'hC0 | 8'($urandom_range(0, 15));
            2: begin
              case ($urandom_range(0, 3))
                0: d = 8'hA7;
                1: d = 8'hE7;
                2: d = 8'h8F;
                default: d = 8'hCF;
              endcase
            end
            default: d = 8'h80 | 8'($urandom_range(0, 127));
          endcase
          bus(0, 0, d, hi);
        end
        6: bus(0, 0, 8'h04 | 8'($urandom_range(0, 3)), hi);
        7: bus(0, 0, d, hi);
        8: bus(1'($urandom_range(0, 1)), 1, d, hi);
        default: bus(0, 0, ($urandom_range(0, 1) == 1) ? (8'h08 | 8'($urandom_range(0, 7)))
                                                      : (8'h20 | 8'($urandom_range(0, 31))), hi);
      endcase
    end
    check_ram();

    // Make sure there is something for reset to wipe
    bus(0, 0, 8'h85, 2);
    bus(1, 0, 8'h5A, 2);
    bus(1, 0, 8'h11, 1);
    bus(0, 1, 8'h00, 2);

    // Reset asserted while E is high with a data write pending
    lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h55;
    @(negedge clk);
    lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    lcd_e = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_strobe", 32'(wr_strobe), 32'd0);
    end
    chk_state();
    check_ram();

    // Bus still operational after reset
    bus(1, 0, 8'h48, 2);
    check_ram();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/text_lcd_responder.md
Name: text_lcd_responder

Overview:
- Synthesizable model of the HD44780-style character LCD at the far end of the textlcd bus. It receives lcd_e/lcd_rs/lcd_rw/lcd_data, decodes instructions and data writes, and maintains a 2x16 display RAM image.
- Used as the on-chip loopback checker and as the bench-side display model for the calculator.
- Exposes the image through a registered read port and a per-write strobe.

Parameters:
- MIN_E_HIGH, 2, minimum number of clk cycles E must be seen high (after synchronization) for a cycle to be accepted.
- BLANK_CHAR, 8'h20, fill value for reset and for the clear-display instruction.

Ports:
- clk  input  1  system clock; much faster than the LCD bus.
- rst  input  1  asynchronous, active-low reset.
- lcd_e  input  1  LCD enable; a bus cycle completes on E falling.
- lcd_rs  input  1  0 = instruction, 1 = data.
- lcd_rw  input  1  0 = write, 1 = read.
- lcd_data  input  8  LCD data bus.
- rd_index  input  5  display cell to read: 0-15 is line 1, 16-31 is line 2.
- rd_char  output  8  contents of cell rd_index; 1-cycle latency.
- wr_strobe  output  1  one-cycle pulse when a data write lands in a visible cell.
- wr_index  output  5  cell written; valid with wr_strobe.
- wr_char  output  8  character written; valid with wr_strobe.
- cursor_addr  output  7  current DDRAM address counter.
- display_on  output  1  D bit of the last display-control instruction.
- two_line  output  1  N bit of the last function-set instruction.
- err_short  output  1  sticky; set when an E pulse is rejected as too short.
- err_read  output  1  sticky; set when a read cycle (rw=1) is completed.

Behaviour:
- Reset (rst=0, asynchronous):
  - All 32 cells = BLANK_CHAR; cursor_addr=0; increment mode I/D=1.
  - display_on=0, two_line=0, err_short=0, err_read=0, wr_strobe=0, rd_char=BLANK_CHAR.
  - Synchronizer flops and the E-high counter are cleared (E treated as low).
  - Reset asserted mid-cycle abandons that cycle; no partial update.
- Synchronization:
  - lcd_e, lcd_rs, lcd_rw and lcd_data pass through a 2-flop synchronizer, then one more flop for edge detection.
  - A fall is seen when the delayed E is 1 and the synchronized E is 0.
  - The rs/rw/data values committed are those in the synchronizer stage that is aligned with the last high E sample.
- E-high counter:
  - Counts synchronized-E-high cycles and saturates at MIN_E_HIGH.
  - Cleared on each fall.
- Commit latency:
  - Clk edge 1 samples E low; edge 2 propagates it; the fall is detected.
  - Edge 3 updates all state.
  - wr_strobe is high for the cycle after edge 3.
- Cycle acceptance:
  - A fall with counter < MIN_E_HIGH is rejected: it sets err_short and changes nothing else.
  - A fall with rw=1 sets err_read and changes nothing else.
- Instruction decode (rs=0, rw=0), highest set bit wins:
  - 1AAAAAAA: cursor_addr=A.
  - 01xxxxxx: CGRAM address; ignored.
  - 001DNFxx: two_line=N.
  - 00001DCB: display_on=D.
  - 000001IS: I/D=I. S (shift) is ignored.
  - 0000001x: cursor_addr=0.
  - 00000001: all cells=BLANK_CHAR, cursor_addr=0, I/D=1.
  - 00000000: no-op.
- Data write (rs=1, rw=0):
  - Address map: 0x00-0x0F -> cells 0-15; 0x40-0x4F -> cells 16-31.
  - Visible address: write the cell and pulse wr_strobe with wr_index/wr_char.
  - Other addresses: the write is discarded and there is no strobe.
  - The address counter always steps, per I/D.
- Address stepping:
  - Increment: 0x27 -> 0x40; 0x67 -> 0x00; otherwise +1.
  - Decrement: 0x00 -> 0x67; 0x40 -> 0x27; otherwise -1.
  - A set-DDRAM value outside both ranges is stored as-is; the next step applies +1/-1, with the same wrap rules at the range ends.
- Read port: rd_char is registered from cell rd_index every cycle. A write and a read of the same cell in the same cycle return the old value.

Test Plan:
- Reset then read all 32 cells -> every rd_char=8'h20; cursor_addr=0; display_on=0; no strobe.
- Send 0x38, 0x0C, 0x06, 0x01 -> two_line=1, display_on=1, I/D=1, cells blank, cursor_addr=0.
- Write data 0x31,0x2B,0x31,0x3D -> cells 0-3 = "1+1=", four wr_strobe pulses at indices 0-3, cursor_addr=4, strobe 3 cycles after each E fall.
- Send 0xCF, then write 0x41,0x42 -> cell 31=0x41, cursor_addr 0x50 after the first write; second write discarded with no strobe; cursor_addr=0x51.
- Send 0x04, 0x80, then write 0x39 -> cell 0=0x39, cursor_addr=0x67. Send 0xA7, write 0x30 -> discarded, cursor_addr=0x26.
- E pulse 1 cycle high with MIN_E_HIGH=2 -> err_short=1, RAM unchanged. A cycle with rw=1 -> err_read=1. Reset asserted during E high -> all reset values restored and no commit on the following E fall.
